lsu_mc: RTL and testbench

- Multi-cycle load/store unit occupying the LSU pipeline stage.
- Accepts one instruction from the EX/LS register and performs the data-memory transaction over a valid/ready request and response bus.
- Extracts and extends load data.
- Is the producer side of the forwarding interface: it drives the lsu_lden/rdwen/rdid/exres/lsres signals the operand-forwarding logic consumes, and a stall that freezes the upstream pipeline while a memory access is outstanding.

---
 rtl/lsu_mc.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mc.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mc.sv
//------------------------------------------------------------------------------
// Module      : lsu_mc
// Description : Multi-cycle load/store unit for the LSU pipeline stage. Holds
//               one instruction in a slot register, runs the data-memory
//               transaction over a valid/ready request / response bus,
//               extracts and extends load data, and drives the forwarding
//               signals and the upstream stall.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lsu_mc #(
  parameter int CPU_WIDTH = 64,
  parameter int REG_ADDRW = 5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic                 i_lden,
  input  logic                 i_sten,
  input  logic [2:0]           i_funct3,
  input  logic                 i_rdwen,
  input  logic [REG_ADDRW-1:0] i_rdid,
  input  logic [CPU_WIDTH-1:0] i_exres,
  input  logic [CPU_WIDTH-1:0] i_rs2,
  output logic                 o_stall,
  output logic                 o_mem_req_valid,
  input  logic                 i_mem_req_ready,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic                 o_mem_wen,
  output logic [CPU_WIDTH-1:0] o_mem_wdata,
  output logic [7:0]           o_mem_wmask,
  input  logic                 i_mem_resp_valid,
  input  logic [CPU_WIDTH-1:0] i_mem_rdata,
  output logic                 o_lsu_lden,
  output logic                 o_lsu_rdwen,
  output logic [REG_ADDRW-1:0] o_lsu_rdid,
  output logic [CPU_WIDTH-1:0] o_lsu_exres,
  output logic [CPU_WIDTH-1:0] o_lsu_lsres,
  output logic                 o_wb_valid,
  output logic                 o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;

  // Slot register
  logic                   r_vld;
  logic                   r_lden;
  logic                   r_sten;
  logic [2:0]             r_funct3;
  logic                   r_rdwen;
  logic [REG_ADDRW-1:0]   r_rdid;
  logic [CPU_WIDTH-1:0]   r_exres;
  logic [CPU_WIDTH-1:0]   r_rs2;
  logic [CPU_WIDTH-1:0]   r_lsres;

  logic                   w_done;
  logic                   w_stall;
  logic                   w_req;
  logic                   w_mem_slot;
  logic                   w_misalign_slot;
  logic                   w_capture_mem;
  logic [2:0]             w_off;
  logic [CPU_WIDTH-1:0]   w_lane;
  logic [CPU_WIDTH-1:0]   w_load_ext;
  logic [7:0]             w_mask_base;

  // Size is funct3[1:0]: 0=byte, 1=half, 2=word, 3=double.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      2'b10:   r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

  assign w_done          = r_vld & (r_state == S_IDLE);
  assign w_stall         = r_vld & ~w_done;
  assign w_req           = (r_state == S_REQ);
  assign w_off           = r_exres[2:0];
  assign w_mem_slot      = r_vld & (r_lden | r_sten);
  assign w_misalign_slot = w_mem_slot & f_misaligned(r_funct3[1:0], w_off);
  // A memory transaction starts only for an aligned access entering the slot.
  assign w_capture_mem   = ~w_stall & i_valid & (i_lden | i_sten)
                         & ~f_misaligned(i_funct3[1:0], i_exres[2:0]);

  // Load lane extraction: bring the addressed byte lane down to bit 0.
  assign w_lane = i_mem_rdata >> {w_off, 3'b000};

  // Size / signedness extension of the selected load lane.
  always_comb begin
    w_load_ext = w_lane;
    case (r_funct3)
      3'b000:  w_load_ext = {{(CPU_WIDTH-8){w_lane[7]}},   w_lane[7:0]};
      3'b001:  w_load_ext = {{(CPU_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_ext = {{(CPU_WIDTH-32){w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_load_ext = {{(CPU_WIDTH-8){1'b0}},        w_lane[7:0]};
      3'b101:  w_load_ext = {{(CPU_WIDTH-16){1'b0}},       w_lane[15:0]};
      3'b110:  w_load_ext = {{(CPU_WIDTH-32){1'b0}},       w_lane[31:0]};
      default: w_load_ext = w_lane;
    endcase
  end

  // Store strobe pattern before shifting to the addressed lane.
  always_comb begin
    w_mask_base = 8'hFF;
    case (r_funct3[1:0])
      2'b00:   w_mask_base = 8'h01;
      2'b01:   w_mask_base = 8'h03;
      2'b10:   w_mask_base = 8'h0F;
      default: w_mask_base = 8'hFF;
    endcase
  end

  // Slot capture when not stalled; load data lands here on the response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld    <= 1'b0;
      r_lden   <= 1'b0;
      r_sten   <= 1'b0;
      r_funct3 <= '0;
      r_rdwen  <= 1'b0;
      r_rdid   <= '0;
      r_exres  <= '0;
      r_rs2    <= '0;
      r_lsres  <= '0;
    end else if (!w_stall) begin
      r_vld    <= i_valid;
      r_lden   <= i_lden;
      r_sten   <= i_sten;
      r_funct3 <= i_funct3;
      r_rdwen  <= i_rdwen;
      r_rdid   <= i_rdid;
      r_exres  <= i_exres;
      r_rs2    <= i_rs2;
      r_lsres  <= '0;
    end else if ((r_state == S_RESP) && i_mem_resp_valid) begin
      r_lsres  <= w_load_ext;
    end
  end

  // Transaction sequencing: IDLE -> REQ -> (RESP for loads) -> IDLE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_capture_mem) r_state <= S_REQ;
        S_REQ:  if (i_mem_req_ready) r_state <= r_lden ? S_RESP : S_IDLE;
        S_RESP: if (i_mem_resp_valid) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request fields come straight from the held slot, so they stay stable
  // until the handshake; they read zero whenever no request is pending.
  assign o_mem_req_valid = w_req;
  assign o_mem_addr      = w_req ? {r_exres[CPU_WIDTH-1:3], 3'b000} : '0;
  assign o_mem_wen       = w_req & r_sten & ~r_lden;
  assign o_mem_wdata     = w_req ? (r_rs2 << {w_off, 3'b000}) : '0;
  assign o_mem_wmask     = w_req ? (w_mask_base << w_off) : 8'h00;

  assign o_stall     = w_stall;
  assign o_wb_valid  = w_done;
  assign o_misalign  = w_done & w_misalign_slot;
  assign o_lsu_rdwen = w_done & r_rdwen & ~w_misalign_slot;
  assign o_lsu_lden  = r_vld & r_lden;
  assign o_lsu_rdid  = r_vld ? r_rdid : '0;
  assign o_lsu_exres = r_vld ? r_exres : '0;
  assign o_lsu_lsres = r_lsres;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mc.sv
//------------------------------------------------------------------------------
// Module      : tb_lsu_mc
// Description : Directed self-checking bench for lsu_mc.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lsu_mc;

  logic        clk;
  logic        rst;
  logic        valid, lden, sten, rdwen;
  logic [2:0]  funct3;
  logic [4:0]  rdid;
  logic [63:0] exres, rs2;
  logic        stall, req_valid, req_ready, mem_wen, resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        lsu_lden, lsu_rdwen, wb_valid, misalign;
  logic [4:0]  lsu_rdid;
  logic [63:0] lsu_exres, lsu_lsres;

  int n_checks = 0;
  int n_errors = 0;

  lsu_mc #(.CPU_WIDTH(64), .REG_ADDRW(5)) u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_valid          (valid),
    .i_lden           (lden),
    .i_sten           (sten),
    .i_funct3         (funct3),
    .i_rdwen          (rdwen),
    .i_rdid           (rdid),
    .i_exres          (exres),
    .i_rs2            (rs2),
    .o_stall          (stall),
    .o_mem_req_valid  (req_valid),
    .i_mem_req_ready  (req_ready),
    .o_mem_addr       (mem_addr),
    .o_mem_wen        (mem_wen),
    .o_mem_wdata      (mem_wdata),
    .o_mem_wmask      (mem_wmask),
    .i_mem_resp_valid (resp_valid),
    .i_mem_rdata      (mem_rdata),
    .o_lsu_lden       (lsu_lden),
    .o_lsu_rdwen      (lsu_rdwen),
    .o_lsu_rdid       (lsu_rdid),
    .o_lsu_exres      (lsu_exres),
    .o_lsu_lsres      (lsu_lsres),
    .o_wb_valid       (wb_valid),
    .o_misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the bench is purely directed, but never let it run away.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, need finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic l, input logic s, input logic [2:0] f3,
                           input logic rw, input logic [4:0] rd,
                           input logic [63:0] ex, input logic [63:0] d);
    valid = 1'b1; lden = l; sten = s; funct3 = f3;
    rdwen = rw; rdid = rd; exres = ex; rs2 = d;
  endtask

  task automatic clear_instr();
    valid = 1'b0; lden = 1'b0; sten = 1'b0; funct3 = 3'd0;
    rdwen = 1'b0; rdid = 5'd0; exres = 64'd0; rs2 = 64'd0;
  endtask

  // Load with ready and response each on the first possible cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input logic [63:0] exp);
    set_instr(1'b1, 1'b0, f3, 1'b1, 5'd3, addr, 64'd0);
    req_ready = 1'b1;
    tick();
    check({tag, "_req_valid"}, {63'd0, req_valid}, 64'd1);
    check({tag, "_addr"}, mem_addr, {addr[63:3], 3'b000});
    check({tag, "_wen"}, {63'd0, mem_wen}, 64'd0);
    check({tag, "_stall1"}, {63'd0, stall}, 64'd1);
    check({tag, "_rdwen_early"}, {63'd0, lsu_rdwen}, 64'd0);
    clear_instr();
    tick();
    req_ready = 1'b0;
    check({tag, "_stall2"}, {63'd0, stall}, 64'd1);
    check({tag, "_req_dropped"}, {63'd0, req_valid}, 64'd0);
    resp_valid = 1'b1;
    mem_rdata  = rdata;
    tick();
    resp_valid = 1'b0;
    check({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    check({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, "_rdwen"}, {63'd0, lsu_rdwen}, 64'd1);
    check({tag, "_lsres"}, lsu_lsres, exp);
  endtask

  // Store with ready held low for 'waits' cycles of the request.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] data, input int waits,
                          input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
    set_instr(1'b0, 1'b1, f3, 1'b0, 5'd0, addr, data);
    req_ready = 1'b0;
    tick();
    for (int k = 0; k <= waits; k++) begin
      if (k == waits) req_ready = 1'b1;
      check({tag, "_stall"}, {63'd0, stall}, 64'd1);
      check({tag, "_req_valid"}, {63'd0, req_valid}, 64'd1);
      check({tag, "_addr"}, mem_addr, {addr[63:3], 3'b000});
      check({tag, "_wen"}, {63'd0, mem_wen}, 64'd1);
      check({tag, "_wmask"}, {56'd0, mem_wmask}, {56'd0, exp_mask});
      check({tag, "_wdata"}, mem_wdata, exp_wdata);
      check({tag, "_rdwen_busy"}, {63'd0, lsu_rdwen}, 64'd0);
      if (k == waits) clear_instr();
      tick();
    end
    req_ready = 1'b0;
    check({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    check({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, "_rdwen_done"}, {63'd0, lsu_rdwen}, 64'd0);
    check({tag, "_req_after"}, {63'd0, req_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    clear_instr();
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_rdata  = 64'd0;
    tick();
    tick();
    // Reset state
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_req", {63'd0, req_valid}, 64'd0);
    check("rst_wb", {63'd0, wb_valid}, 64'd0);
    check("rst_rdwen", {63'd0, lsu_rdwen}, 64'd0);
    check("rst_lsres", lsu_lsres, 64'd0);
    rst = 1'b0;

    // ADD-type: completes in its capture cycle
    set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd5, 64'h1234, 64'd0);
    tick();
    check("add_rdwen", {63'd0, lsu_rdwen}, 64'd1);
    check("add_rdid", {59'd0, lsu_rdid}, 64'd5);
    check("add_exres", lsu_exres, 64'h1234);
    check("add_wb", {63'd0, wb_valid}, 64'd1);
    check("add_stall", {63'd0, stall}, 64'd0);
    check("add_req", {63'd0, req_valid}, 64'd0);
    clear_instr();

    // Loads
    do_load("lb",  3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    check("lb_rdwen_after", {63'd0, lsu_rdwen}, 64'd0);
    do_load("lh",  3'b001, 64'h6006, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    do_load("lbu", 3'b100, 64'h1005, 64'h0000_F000_0000_0000, 64'h0000_0000_0000_00F0);

    // Stores
    do_store("sh", 3'b001, 64'h2006, 64'hABCD, 3, 8'hC0, 64'hABCD_0000_0000_0000);
    do_store("sw", 3'b010, 64'h7004, 64'h1122_3344, 0, 8'hF0, 64'h1122_3344_0000_0000);
    do_store("sb", 3'b000, 64'h8007, 64'h55A5, 0, 8'h80, 64'hA500_0000_0000_0000);

    // Misaligned LW: no request, immediate completion, rd suppressed
    set_instr(1'b1, 1'b0, 3'b010, 1'b1, 5'd9, 64'h3002, 64'd0);
    tick();
    check("lw_mis_misalign", {63'd0, misalign}, 64'd1);
    check("lw_mis_rdwen", {63'd0, lsu_rdwen}, 64'd0);
    check("lw_mis_stall", {63'd0, stall}, 64'd0);
    check("lw_mis_req", {63'd0, req_valid}, 64'd0);
    check("lw_mis_wb", {63'd0, wb_valid}, 64'd1);
    clear_instr();
    tick();
    check("lw_mis_clear", {63'd0, misalign}, 64'd0);

    // LWU with reset pulsed in RESP, then a late response
    set_instr(1'b1, 1'b0, 3'b110, 1'b1, 5'd4, 64'h4004, 64'd0);
    req_ready = 1'b1;
    tick();
    check("rstmid_req", {63'd0, req_valid}, 64'd1);
    clear_instr();
    tick();
    req_ready = 1'b0;
    check("rstmid_in_resp", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    #2;
    check("rstmid_stall", {63'd0, stall}, 64'd0);
    check("rstmid_lden", {63'd0, lsu_lden}, 64'd0);
    check("rstmid_exres", lsu_exres, 64'd0);
    check("rstmid_wb", {63'd0, wb_valid}, 64'd0);
    tick();
    rst = 1'b0;
    resp_valid = 1'b1;
    mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    resp_valid = 1'b0;
    check("late_resp_lsres", lsu_lsres, 64'd0);
    check("late_resp_rdwen", {63'd0, lsu_rdwen}, 64'd0);
    check("late_resp_stall", {63'd0, stall}, 64'd0);
    do_load("lwu", 3'b110, 64'h4004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);

    // LD followed by a dependent ADD held upstream
    set_instr(1'b1, 1'b0, 3'b011, 1'b1, 5'd10, 64'h5000, 64'd0);
    req_ready = 1'b1;
    tick();
    set_instr(1'b0, 1'b0, 3'd0, 1'b1, 5'd11, 64'h77, 64'd0);
    check("ld_stall_req", {63'd0, stall}, 64'd1);
    check("ld_rdid_held1", {59'd0, lsu_rdid}, 64'd10);
    tick();
    req_ready  = 1'b0;
    resp_valid = 1'b1;
    mem_rdata  = 64'h0123_4567_89AB_CDEF;
    check("ld_stall_resp", {63'd0, stall}, 64'd1);
    check("ld_rdid_held2", {59'd0, lsu_rdid}, 64'd10);
    tick();
    resp_valid = 1'b0;
    check("ld_lsres", lsu_lsres, 64'h0123_4567_89AB_CDEF);
    check("ld_rdwen", {63'd0, lsu_rdwen}, 64'd1);
    check("ld_lden", {63'd0, lsu_lden}, 64'd1);
    check("ld_rdid", {59'd0, lsu_rdid}, 64'd10);
    tick();
    check("dep_add_rdid", {59'd0, lsu_rdid}, 64'd11);
    check("dep_add_exres", lsu_exres, 64'h77);
    check("dep_add_lden", {63'd0, lsu_lden}, 64'd0);
    check("dep_add_wb", {63'd0, wb_valid}, 64'd1);
    clear_instr();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
